// File: rtl/int_gen_pkg.sv
// Shared definitions for the PC-triggered interrupt generator:
// FSM state encoding, default acknowledge address and a saturating counter helper.
package int_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/int_gen_table.sv
// Trigger table: DEPTH entries of {valid, pc, delay}. One write port, one
// valid-clear port and a combinational read of the entry at the read index.
module int_gen_table #(
    parameter int DEPTH = 4,
    parameter int DLY_W = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wpc,
    input  logic [DLY_W-1:0] wdelay,
    input  logic             clr,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [31:0]      rpc,
    output logic [DLY_W-1:0] rdelay
);

    logic [DEPTH-1:0] valid;
    logic [31:0]      pc_mem  [DEPTH];
    logic [DLY_W-1:0] dly_mem [DEPTH];

    // The write is applied after the clear so a same-cycle write to the
    // entry being retired leaves it valid with the new contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (clr) valid[ridx] <= 1'b0;
            if (we)  valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem[widx]  <= wpc;
            dly_mem[widx] <= wdelay;
        end
    end

    assign rvalid = valid[ridx];
    assign rpc    = pc_mem[ridx];
    assign rdelay = dly_mem[ridx];

endmodule

// File: rtl/int_gen.sv
// Raises an interrupt a programmed number of cycles after the CPU's M-stage PC
// hits the active trigger entry; entries fire strictly in index order.
module int_gen
    import int_gen_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEFAULT,
    parameter int          DLY_W    = 8,
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_pc,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      int_addr,
    input  logic [3:0]       int_byteen,
    output logic             interrupt,
    output logic [1:0]       state_o,
    output logic [7:0]       fired_cnt
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [DLY_W-1:0] cnt;
    logic             ent_valid;
    logic [31:0]      ent_pc;
    logic [DLY_W-1:0] ent_delay;
    logic             ack_hit;
    logic             retire;
    logic             match;

    // Handshake: interrupt is held high until the CPU acknowledges it with an
    // access to ACK_ADDR with any byte enable set; acks outside ASSERT are ignored.
    assign ack_hit = (int_addr == ACK_ADDR) && (int_byteen != 4'b0000);
    assign retire  = (state == ST_ASSERT) && ack_hit;
    assign match   = enable && ent_valid && (macroscopic_pc == ent_pc);

    int_gen_table #(
        .DEPTH (DEPTH),
        .DLY_W (DLY_W),
        .IDX_W (IDX_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (cfg_we),
        .widx   (cfg_idx),
        .wpc    (cfg_pc),
        .wdelay (cfg_delay),
        .clr    (retire),
        .ridx   (ptr),
        .rvalid (ent_valid),
        .rpc    (ent_pc),
        .rdelay (ent_delay)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            fired_cnt <= '0;
        end else begin
            // interrupt trails the registered ASSERT state by one cycle and
            // drops on the same edge that retires the entry.
            interrupt <= (state == ST_ASSERT) && !ack_hit;
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        cnt   <= ent_delay;
                        state <= (ent_delay == '0) ? ST_ASSERT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == DLY_W'(1)) state <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (ack_hit) begin
                        state     <= ST_IDLE;
                        ptr       <= ptr + 1'b1;
                        fired_cnt <= sat_inc8(fired_cnt);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: stimulus pushes the expected {rise cycle, fired_cnt}
// of each interrupt; a negedge monitor pops and compares on every rising interrupt.
module tb_int_gen;
  localparam logic [31:0] ACK = 32'h0000_7F20;
  localparam int W = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_pc = '0;
  logic [7:0]  cfg_delay = '0;
  logic [31:0] macroscopic_pc = '0;
  logic [31:0] int_addr = '0;
  logic [3:0]  int_byteen = '0;
  logic        interrupt;
  logic [1:0]  state_o;
  logic [7:0]  fired_cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] cyc = '0;
  logic [W-1:0] exp_q[$];
  logic [7:0] exp_fired = '0;
  logic [1:0] ptr_m = '0;
  logic prev_int = 1'b0;

  int_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pc(cfg_pc), .cfg_delay(cfg_delay), .macroscopic_pc(macroscopic_pc),
    .int_addr(int_addr), .int_byteen(int_byteen), .interrupt(interrupt),
    .state_o(state_o), .fired_cnt(fired_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (interrupt && !prev_int) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_irq: rise at cycle %0d with no expected interrupt", cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({cyc, fired_cnt} !== e) begin
          bad++;
          $display("FAIL irq_rise: got cyc=%0d cnt=%0d expected cyc=%0d cnt=%0d",
                   cyc, fired_cnt, e[23:8], e[7:0]);
        end
      end
    end
    prev_int <= interrupt;
  end

  // driver tasks (enter and leave aligned to a negedge)
  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] pc, input logic [7:0] dly);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pc = pc; cfg_delay = dly;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic trigger(input logic [31:0] pc, input logic [7:0] dly);
    exp_q.push_back({cyc + 16'd2 + 16'(dly), exp_fired});
    macroscopic_pc = pc;
    @(negedge clk);
    macroscopic_pc = '0;
  endtask

  task automatic wait_int();
    int i;
    for (i = 0; i < 40; i++) begin
      if (interrupt) break;
      @(negedge clk);
    end
    if (i == 40) begin
      total++; bad++;
      $display("FAIL irq_timeout: interrupt not raised within 40 cycles");
    end
  endtask

  task automatic do_ack();
    int_addr = ACK; int_byteen = 4'b1111;
    @(negedge clk);
    int_addr = '0; int_byteen = '0;
    exp_fired = (exp_fired == 8'hFF) ? exp_fired : exp_fired + 8'd1;
    ptr_m = ptr_m + 2'd1;
    check("ack_irq_low", {31'd0, interrupt}, 32'd0);
    check("ack_fired_cnt", {24'd0, fired_cnt}, {24'd0, exp_fired});
  endtask

  task automatic fire(input logic [31:0] pc, input logic [7:0] dly);
    cfg_write(ptr_m, pc, dly);
    trigger(pc, dly);
    wait_int();
    do_ack();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_irq", {31'd0, interrupt}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_fired", {24'd0, fired_cnt}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // zero-delay trigger, ack, ptr advances
    enable = 1'b1;
    cfg_write(2'd0, 32'h3010, 8'd0);
    trigger(32'h3010, 8'd0);
    wait_int();
    check("assert_state", {30'd0, state_o}, 32'd2);
    do_ack();
    check("idle_after_ack", {30'd0, state_o}, 32'd0);
    // entry0 retired: the same PC must not fire again (monitor flags any rise)
    macroscopic_pc = 32'h3010;
    repeat (4) @(negedge clk);
    macroscopic_pc = '0;
    check("no_refire_state", {30'd0, state_o}, 32'd0);

    // delay 3 on entry1
    cfg_write(2'd1, 32'h4000, 8'd3);
    trigger(32'h4000, 8'd3);
    wait_int();
    do_ack();

    // abort in the 2nd WAIT cycle
    cfg_write(2'd2, 32'h5000, 8'd3);
    macroscopic_pc = 32'h5000;
    @(negedge clk);
    macroscopic_pc = '0;
    check("wait_state", {30'd0, state_o}, 32'd1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_state", {30'd0, state_o}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_irq", {31'd0, interrupt}, 32'd0);
    enable = 1'b1;
    trigger(32'h5000, 8'd3);
    wait_int();

    // non-matching acks are ignored
    int_addr = ACK; int_byteen = 4'b0000;
    @(negedge clk);
    int_addr = 32'h7F24; int_byteen = 4'b1111;
    @(negedge clk);
    int_addr = '0; int_byteen = '0;
    check("bad_ack_irq", {31'd0, interrupt}, 32'd1);
    check("bad_ack_state", {30'd0, state_o}, 32'd2);
    do_ack();

    // entry3, then wrap to a reprogrammed entry0
    fire(32'h6000, 8'd1);
    check("ptr_wrapped", {30'd0, ptr_m}, 32'd0);
    fire(32'h7000, 8'd2);

    // saturation: 260 fires total
    for (int k = 0; k < 255; k++) fire(32'h8000 + k, 8'd0);
    check("fired_sat", {24'd0, fired_cnt}, 32'd255);

    // ack and cfg write to the active entry in the same cycle
    begin
      logic [1:0] p;
      p = ptr_m;
      cfg_write(p, 32'hB000, 8'd0);
      trigger(32'hB000, 8'd0);
      wait_int();
      int_addr = ACK; int_byteen = 4'b1111;
      cfg_we = 1'b1; cfg_idx = p; cfg_pc = 32'hC000; cfg_delay = 8'd0;
      @(negedge clk);
      int_addr = '0; int_byteen = '0; cfg_we = 1'b0;
      ptr_m = ptr_m + 2'd1;
      check("cfg_ack_irq_low", {31'd0, interrupt}, 32'd0);
      for (int k = 0; k < 3; k++) fire(32'hD000 + k, 8'd0);
      check("back_to_p", {30'd0, ptr_m}, {30'd0, p});
      trigger(32'hC000, 8'd0);
      wait_int();
      do_ack();
    end

    // async reset while asserted
    cfg_write(ptr_m, 32'hE000, 8'd0);
    trigger(32'hE000, 8'd0);
    wait_int();
    reset = 1'b0;
    #1;
    check("rst_async_irq", {31'd0, interrupt}, 32'd0);
    check("rst_async_state", {30'd0, state_o}, 32'd0);
    check("rst_async_fired", {24'd0, fired_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_fired = '0;
    ptr_m = '0;
    @(negedge clk);
    fire(32'hA000, 8'd0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
